// File: rtl/speck_input_loader.sv
// speck_input_loader: assembles 32-bit words (MSW first) into the 128-bit
// SPECK128/128 key and plaintext buses, issues a one-cycle start pulse and
// holds both buses until the downstream chain reports completion.
// Optional feature macro: SPECK_LOADER_KEY_REUSE_EN (a block may skip the key
// load and reuse the previously loaded key when key_reuse is set at finish).
module speck_input_loader #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             key_reuse,
  output logic [127:0]     key,
  output logic [127:0]     plaintext,
  output logic             signal_start,
  input  logic             finished,
  output logic             busy,
  output logic [CNT_W-1:0] block_count
);

  typedef enum logic [1:0] {
    LOAD_KEY  = 2'd0,
    LOAD_PT   = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [1:0]       word_cnt_q, word_cnt_d;
  logic [127:0]     key_q, key_d;
  logic [127:0]     pt_q, pt_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             start_q, start_d;
  logic             accept_s;

`ifdef SPECK_LOADER_KEY_REUSE_EN
  logic             key_loaded_q, key_loaded_d;
`else
  logic             unused_key_reuse_s;
  assign unused_key_reuse_s = key_reuse;
`endif

  // Next-state, word assembly and block counting.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    key_d      = key_q;
    pt_d       = pt_q;
    blk_cnt_d  = blk_cnt_q;
`ifdef SPECK_LOADER_KEY_REUSE_EN
    key_loaded_d = key_loaded_q;
`endif
    accept_s = in_valid && ((state_q == LOAD_KEY) || (state_q == LOAD_PT));

    case (state_q)
      LOAD_KEY: begin
        if (accept_s) begin
          key_d      = {key_q[95:0], in_data};
          word_cnt_d = word_cnt_q + 2'd1;
          if (word_cnt_q == 2'd3) begin
            state_d = LOAD_PT;
`ifdef SPECK_LOADER_KEY_REUSE_EN
            key_loaded_d = 1'b1;
`endif
          end else begin
            state_d = LOAD_KEY;
          end
        end else begin
          state_d = LOAD_KEY;
        end
      end
      LOAD_PT: begin
        if (accept_s) begin
          pt_d       = {pt_q[95:0], in_data};
          word_cnt_d = word_cnt_q + 2'd1;
          if (word_cnt_q == 2'd3) begin
            state_d = START;
          end else begin
            state_d = LOAD_PT;
          end
        end else begin
          state_d = LOAD_PT;
        end
      end
      START: begin
        // finished is deliberately ignored here: the chain has not started yet
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (finished) begin
          blk_cnt_d = blk_cnt_q + CNT_ONE;
`ifdef SPECK_LOADER_KEY_REUSE_EN
          if (key_reuse && key_loaded_q) begin
            state_d = LOAD_PT;
          end else begin
            state_d = LOAD_KEY;
          end
`else
          state_d = LOAD_KEY;
`endif
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = LOAD_KEY;
      end
    endcase

    // Outputs are registered from the next state so they line up with it
    in_ready_d = (state_d == LOAD_KEY) || (state_d == LOAD_PT);
    busy_d     = (state_d == START) || (state_d == WAIT_DONE);
    start_d    = (state_d == START);
  end

  // State, data and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD_KEY;
      word_cnt_q <= 2'd0;
      key_q      <= 128'd0;
      pt_q       <= 128'd0;
      blk_cnt_q  <= {CNT_W{1'b0}};
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
`ifdef SPECK_LOADER_KEY_REUSE_EN
      key_loaded_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      key_q      <= key_d;
      pt_q       <= pt_d;
      blk_cnt_q  <= blk_cnt_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
`ifdef SPECK_LOADER_KEY_REUSE_EN
      key_loaded_q <= key_loaded_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign signal_start = start_q;
  assign key          = key_q;
  assign plaintext    = pt_q;
  assign block_count  = blk_cnt_q;

endmodule

// File: tb/tb_speck_input_loader.sv
// Self-checking bench for speck_input_loader with a word-index based model.
module tb_speck_input_loader;

  localparam int CW = 4;
`ifdef SPECK_LOADER_KEY_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   in_data = 32'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          key_reuse = 1'b0;
  logic [127:0]  key;
  logic [127:0]  plaintext;
  logic          signal_start;
  logic          finished = 1'b0;
  logic          busy;
  logic [CW-1:0] block_count;

  always #5 clk = ~clk;

  speck_input_loader #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .key_reuse(key_reuse), .key(key),
    .plaintext(plaintext), .signal_start(signal_start), .finished(finished),
    .busy(busy), .block_count(block_count)
  );

  // Model: m_got = words of the current block already taken (0..8)
  logic [127:0] m_key = 128'd0;
  logic [127:0] m_pt  = 128'd0;
  int           m_got = 0;
  bit           m_start = 1'b0;
  bit           m_kl = 1'b0;
  int           m_cnt = 0;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]  basic_w [8];
  logic [31:0]  cur_w [8];
  logic [127:0] saved_key;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model, advanced on every rising edge or reset assertion
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_key = 128'd0; m_pt = 128'd0; m_got = 0; m_start = 1'b0; m_kl = 1'b0; m_cnt = 0;
    end else if (m_start) begin
      m_start = 1'b0;
    end else if (m_got == 8) begin
      if (finished) begin
        m_cnt = (m_cnt + 1) % (1 << CW);
        m_got = (REUSE && key_reuse && m_kl) ? 4 : 0;
      end
    end else if (in_valid) begin
      if (m_got < 4) m_key = {m_key[95:0], in_data};
      else           m_pt  = {m_pt[95:0], in_data};
      m_got++;
      if (m_got == 4) m_kl = 1'b1;
      if (m_got == 8) m_start = 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      chk("in_ready", in_ready, (m_got < 8));
      chk("busy", busy, (m_got == 8));
      chk("signal_start", signal_start, m_start);
      chk("key", key, m_key);
      chk("plaintext", plaintext, m_pt);
      chk("block_count", block_count, m_cnt);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic load_words(input int upto, input int vprob);
    int guard;
    guard = 0;
    while (m_got < upto && guard < 400) begin
      in_data  = cur_w[m_got];
      in_valid = ($urandom_range(99) < vprob);
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    if (m_got < upto) chk("load_timeout", m_got, upto);
  endtask

  // Called in the START cycle; returns in the first cycle after completion
  task automatic finish_block(input bit fin_start, input int delay, input bit reuse);
    finished  = fin_start;
    key_reuse = $urandom_range(1);
    in_valid  = $urandom_range(1);
    in_data   = $urandom;
    @(negedge clk);
    repeat (delay) begin
      finished  = 1'b0;
      key_reuse = $urandom_range(1);
      in_valid  = $urandom_range(1);
      in_data   = $urandom;
      @(negedge clk);
    end
    finished  = 1'b1;
    key_reuse = reuse;
    in_valid  = 1'b0;
    @(negedge clk);
    finished  = 1'b0;
    key_reuse = 1'b0;
  endtask

  task automatic rand_words();
    for (int i = 0; i < 8; i++) cur_w[i] = $urandom;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_key"}, key, 128'd0);
    chk({tag, "_pt"}, plaintext, 128'd0);
    chk({tag, "_start"}, signal_start, 1'b0);
    chk({tag, "_count"}, block_count, 4'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    basic_w = '{32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
                32'h6c617669, 32'h75716520, 32'h74692065, 32'h64616d20};
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Basic back-to-back load
    cur_w = basic_w;
    load_words(8, 100);
    chk("A_start", signal_start, 1'b1);
    chk("A_key", key, 128'h0f0e0d0c0b0a09080706050403020100);
    chk("A_pt", plaintext, 128'h6c617669757165207469206564616d20);
    @(negedge clk);
    chk("A_pulse_end", signal_start, 1'b0);
    chk("A_busy", busy, 1'b1);
    finished = 1'b1;
    @(negedge clk);
    finished = 1'b0;
    chk("A_ready", in_ready, 1'b1);
    chk("A_count", block_count, 4'd1);

    // Random stalls on in_valid
    load_words(8, 35);
    chk("B_key", key, 128'h0f0e0d0c0b0a09080706050403020100);
    chk("B_pt", plaintext, 128'h6c617669757165207469206564616d20);
    finish_block(1'b0, 3, 1'b0);
    chk("B_count", block_count, 4'd2);

    // Long wait for finished, with junk valid words offered meanwhile
    load_words(8, 100);
    repeat (50) begin
      in_valid = $urandom_range(1);
      in_data  = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("C_busy", busy, 1'b1);
    chk("C_ready", in_ready, 1'b0);
    chk("C_key", key, 128'h0f0e0d0c0b0a09080706050403020100);
    chk("C_pt", plaintext, 128'h6c617669757165207469206564616d20);
    chk("C_count_hold", block_count, 4'd2);
    finished = 1'b1;
    @(negedge clk);
    finished = 1'b0;
    chk("C_count", block_count, 4'd3);
    chk("C_ready_after", in_ready, 1'b1);

    // finished only during START must be ignored
    load_words(8, 100);
    finish_block(1'b1, 4, 1'b0);
    chk("C2_count", block_count, 4'd4);

    // Reset after the 5th word
    rand_words();
    load_words(5, 100);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    cur_w = basic_w;
    load_words(8, 60);
    chk("D_key", key, 128'h0f0e0d0c0b0a09080706050403020100);
    chk("D_pt", plaintext, 128'h6c617669757165207469206564616d20);
    finish_block(1'b0, 0, 1'b0);
    chk("D_count", block_count, 4'd1);

    // Counter wrap: 17 blocks from reset with a 4-bit counter
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int b = 0; b < 17; b++) begin
      rand_words();
      load_words(8, $urandom_range(40, 100));
      finish_block($urandom_range(1), $urandom_range(0, 4), 1'b0);
    end
    chk("E_wrap", block_count, 4'd1);

    // Key reuse request at finish
    rand_words();
    load_words(8, 100);
    saved_key = key;
    finish_block(1'b0, 1, 1'b1);
    chk("F_first_word", m_got, REUSE ? 4 : 0);
    rand_words();
    load_words(8, 100);
    chk("F_key", key, REUSE ? saved_key : {cur_w[0], cur_w[1], cur_w[2], cur_w[3]});
    chk("F_pt", plaintext, {cur_w[4], cur_w[5], cur_w[6], cur_w[7]});
    finish_block(1'b0, 0, 1'b0);

    // Randomized mix including reuse requests
    for (int b = 0; b < 20; b++) begin
      rand_words();
      load_words(8, $urandom_range(30, 100));
      finish_block($urandom_range(1), $urandom_range(0, 5), $urandom_range(1));
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
